// File: rtl/eeprom_pkg.sv
// Shared types and defaults for the serial EEPROM responder.
package eeprom_pkg;

   localparam int         ADDR_W_DEFAULT    = 11;
   localparam int         PAGE_BITS_DEFAULT = 4;
   localparam logic [3:0] DEV_TYPE_DEFAULT  = 4'b1010;

   typedef enum logic [3:0] {
      IDLE,
      CTRL,
      CTRL_ACK,
      ADDR,
      ADDR_ACK,
      WDATA,
      WDATA_ACK,
      RDATA,
      RDATA_ACK,
      WAIT
   } state_t;

endpackage

// File: rtl/i2c_line_detect.sv
// Synchronizes SCL/SDA into the CLK domain and decodes SCL edges and
// START/STOP conditions as one-CLK pulses, plus the synced SDA level.
module i2c_line_detect #(
   parameter int SYNC_STAGES = 2
) (
   input  logic CLK,
   input  logic RESET,
   input  logic SCL,
   input  logic SDA_IN,
   output logic sda_s,
   output logic scl_rise,
   output logic scl_fall,
   output logic start,
   output logic stop
);

   logic [SYNC_STAGES-1:0] scl_sync;
   logic [SYNC_STAGES-1:0] sda_sync;
   logic                   scl_s;
   logic                   scl_q;
   logic                   sda_q;

   // Shift both lines through the synchronizer chain and keep one extra
   // delayed copy for edge detection; the idle bus level is high.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_q    <= 1'b1;
         sda_q    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], SCL};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], SDA_IN};
         scl_q    <= scl_s;
         sda_q    <= sda_s;
      end
   end

   assign scl_s    = scl_sync[SYNC_STAGES-1];
   assign sda_s    = sda_sync[SYNC_STAGES-1];
   assign scl_rise = scl_s & ~scl_q;
   assign scl_fall = ~scl_s & scl_q;
   // START/STOP need SCL high on both samples, so they never coincide with an SCL edge.
   assign start    = scl_s & scl_q & sda_q & ~sda_s;
   assign stop     = scl_s & scl_q & ~sda_q & sda_s;

endmodule

// File: rtl/eeprom_slave_rsp.sv
// Slave end of a 24C16-type serial EEPROM: decodes control byte, word
// address and data bytes, ACKs, and drives read data onto SDA while
// talking to an external synchronous byte memory.
// Optional build macro EEPROM_WRITE_PROTECT_EN adds a WP input that
// suppresses memory writes while still ACKing data bytes.
module eeprom_slave_rsp
   import eeprom_pkg::*;
#(
   parameter int         ADDR_W      = ADDR_W_DEFAULT,
   parameter int         PAGE_BITS   = PAGE_BITS_DEFAULT,
   parameter int         SYNC_STAGES = 2,
   parameter logic [3:0] DEV_TYPE    = DEV_TYPE_DEFAULT
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              SCL,
   input  logic              SDA_IN,
`ifdef EEPROM_WRITE_PROTECT_EN
   input  logic              WP,
`endif
   output logic              SDA_OE,
   output logic [ADDR_W-1:0] MEM_ADDR,
   output logic [7:0]        MEM_WDATA,
   output logic              MEM_WE,
   input  logic [7:0]        MEM_RDATA,
   output logic              BUSY
);

   state_t            state;
   logic [3:0]        bit_cnt;
   logic [7:0]        shreg;
   logic [ADDR_W-1:0] ptr;
   logic              rw;
   logic              sda_s;
   logic              scl_rise;
   logic              scl_fall;
   logic              start;
   logic              stop;
   logic [7:0]        rx_byte;
   logic              last_bit;
   logic              wr_block;

   i2c_line_detect #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_line (
      .CLK     (CLK),
      .RESET   (RESET),
      .SCL     (SCL),
      .SDA_IN  (SDA_IN),
      .sda_s   (sda_s),
      .scl_rise(scl_rise),
      .scl_fall(scl_fall),
      .start   (start),
      .stop    (stop)
   );

`ifdef EEPROM_WRITE_PROTECT_EN
   assign wr_block = WP;
`else
   assign wr_block = 1'b0;
`endif

   assign rx_byte  = {shreg[6:0], sda_s};
   assign last_bit = (bit_cnt == 4'd7);

   // Protocol state machine: START/STOP override everything, otherwise
   // bits are taken on SCL rise and SDA_OE only moves after an SCL fall.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= IDLE;
         bit_cnt   <= 4'd0;
         shreg     <= 8'd0;
         ptr       <= '0;
         rw        <= 1'b0;
         SDA_OE    <= 1'b0;
         MEM_ADDR  <= '0;
         MEM_WDATA <= 8'd0;
         MEM_WE    <= 1'b0;
         BUSY      <= 1'b0;
      end else begin
         MEM_WE <= 1'b0;
         if (start) begin
            state   <= CTRL;
            bit_cnt <= 4'd0;
            SDA_OE  <= 1'b0;
            BUSY    <= 1'b1;
         end else if (stop) begin
            state   <= IDLE;
            bit_cnt <= 4'd0;
            SDA_OE  <= 1'b0;
            BUSY    <= 1'b0;
         end else begin
            case (state)
               CTRL: begin
                  if (scl_rise) begin
                     shreg <= rx_byte;
                     if (last_bit) begin
                        bit_cnt <= 4'd0;
                        if (rx_byte[7:4] == DEV_TYPE) begin
                           ptr[ADDR_W-1:8] <= rx_byte[ADDR_W-8:1];
                           rw              <= rx_byte[0];
                           state           <= CTRL_ACK;
                        end else begin
                           state <= WAIT;
                        end
                     end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                     end
                  end
               end
               CTRL_ACK: begin
                  if (scl_fall) begin
                     if (bit_cnt == 4'd0) begin
                        SDA_OE  <= 1'b1;
                        bit_cnt <= 4'd1;
                        if (rw) begin
                           MEM_ADDR <= ptr;
                        end
                     end else begin
                        bit_cnt <= 4'd0;
                        if (rw) begin
                           shreg  <= MEM_RDATA;
                           SDA_OE <= ~MEM_RDATA[7];
                           state  <= RDATA;
                        end else begin
                           SDA_OE <= 1'b0;
                           state  <= ADDR;
                        end
                     end
                  end
               end
               ADDR: begin
                  if (scl_rise) begin
                     shreg <= rx_byte;
                     if (last_bit) begin
                        bit_cnt  <= 4'd0;
                        ptr[7:0] <= rx_byte;
                        state    <= ADDR_ACK;
                     end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                     end
                  end
               end
               WDATA: begin
                  if (scl_rise) begin
                     shreg <= rx_byte;
                     if (last_bit) begin
                        bit_cnt                <= 4'd0;
                        MEM_WDATA              <= rx_byte;
                        MEM_ADDR               <= ptr;
                        MEM_WE                 <= ~wr_block;
                        ptr[PAGE_BITS-1:0]     <= ptr[PAGE_BITS-1:0] + PAGE_BITS'(1);
                        state                  <= WDATA_ACK;
                     end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                     end
                  end
               end
               ADDR_ACK, WDATA_ACK: begin
                  if (scl_fall) begin
                     if (bit_cnt == 4'd0) begin
                        SDA_OE  <= 1'b1;
                        bit_cnt <= 4'd1;
                     end else begin
                        SDA_OE  <= 1'b0;
                        bit_cnt <= 4'd0;
                        state   <= WDATA;
                     end
                  end
               end
               RDATA: begin
                  if (scl_rise) begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end else if (scl_fall) begin
                     if (bit_cnt == 4'd8) begin
                        SDA_OE  <= 1'b0;
                        bit_cnt <= 4'd0;
                        ptr     <= ptr + ADDR_W'(1);
                        state   <= RDATA_ACK;
                     end else begin
                        shreg  <= {shreg[6:0], 1'b0};
                        SDA_OE <= ~shreg[6];
                     end
                  end
               end
               RDATA_ACK: begin
                  if (scl_rise) begin
                     if (!sda_s) begin
                        MEM_ADDR <= ptr;
                        bit_cnt  <= 4'd1;
                     end else begin
                        state <= WAIT;
                     end
                  end else if (scl_fall && bit_cnt == 4'd1) begin
                     bit_cnt <= 4'd0;
                     shreg   <= MEM_RDATA;
                     SDA_OE  <= ~MEM_RDATA[7];
                     state   <= RDATA;
                  end
               end
               IDLE, WAIT: begin
                  bit_cnt <= 4'd0;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_eeprom_slave_rsp.sv
// Bench for eeprom_slave_rsp: a bit-level bus master, a 2K x 8 synchronous
// memory, and a byte-level reference model of the EEPROM contents/pointer.
module tb_eeprom_slave_rsp;

   localparam int QTR = 4;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        SCL;
   logic        sda_master;
   logic        SDA_OE;
   logic [10:0] MEM_ADDR;
   logic [7:0]  MEM_WDATA;
   logic        MEM_WE;
   logic [7:0]  MEM_RDATA;
   logic        BUSY;
`ifdef EEPROM_WRITE_PROTECT_EN
   logic        WP;
`endif
   wire         sda_line = sda_master & ~SDA_OE;

   logic [7:0]  ram [0:2047];
   logic        preload_en;
   logic [10:0] preload_addr;
   logic [7:0]  preload_data;

   logic [10:0] wr_addr_log [0:255];
   logic [7:0]  wr_data_log [0:255];
   int          wr_count = 0;
   int          oe_count = 0;

   logic [7:0]  model_mem [0:2047];
   int          model_ptr = 0;
   logic [7:0]  data_buf [0:7];

   int          checks = 0;
   int          failures = 0;

   eeprom_slave_rsp dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .SCL      (SCL),
      .SDA_IN   (sda_line),
`ifdef EEPROM_WRITE_PROTECT_EN
      .WP       (WP),
`endif
      .SDA_OE   (SDA_OE),
      .MEM_ADDR (MEM_ADDR),
      .MEM_WDATA(MEM_WDATA),
      .MEM_WE   (MEM_WE),
      .MEM_RDATA(MEM_RDATA),
      .BUSY     (BUSY)
   );

   // System clock
   always #5 CLK = ~CLK;

   // External synchronous memory with a bench-side preload port
   always @(posedge CLK) begin
      if (preload_en) begin
         ram[preload_addr] <= preload_data;
      end else if (MEM_WE) begin
         ram[MEM_ADDR] <= MEM_WDATA;
      end
      MEM_RDATA <= ram[MEM_ADDR];
   end

   // Record every CLK with MEM_WE high and count CLKs with SDA pulled low
   always @(negedge CLK) begin
      if (MEM_WE) begin
         wr_addr_log[8'(wr_count)] <= MEM_ADDR;
         wr_data_log[8'(wr_count)] <= MEM_WDATA;
         wr_count <= wr_count + 1;
      end
      if (SDA_OE) begin
         oe_count <= oe_count + 1;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_q();
      repeat (QTR) @(negedge CLK);
   endtask

   task automatic preload(input logic [10:0] a, input logic [7:0] d);
      preload_en   = 1'b1;
      preload_addr = a;
      preload_data = d;
      model_mem[a] = d;
      @(negedge CLK);
      preload_en   = 1'b0;
   endtask

   task automatic send_start();
      sda_master = 1'b1;
      wait_q();
      SCL = 1'b1;
      wait_q();
      sda_master = 1'b0;
      wait_q();
      SCL = 1'b0;
      wait_q();
   endtask

   task automatic send_stop();
      sda_master = 1'b0;
      wait_q();
      SCL = 1'b1;
      wait_q();
      sda_master = 1'b1;
      wait_q();
      wait_q();
   endtask

   task automatic clock_bit(input logic b, output logic s);
      sda_master = b;
      wait_q();
      SCL = 1'b1;
      wait_q();
      s = sda_line;
      wait_q();
      SCL = 1'b0;
      wait_q();
   endtask

   // Master sends one byte MSB first and reports whether the slave ACKed
   task automatic applyStimulus(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         clock_bit(b[i], s);
      end
      clock_bit(1'b1, s);
      ack = ~s;
   endtask

   task automatic read_byte(input logic m_ack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         clock_bit(1'b1, s);
         d[i] = s;
      end
      clock_bit(~m_ack, s);
   endtask

   // Page write of n bytes from data_buf starting at addr
   task automatic do_write(input int addr, input int n);
      logic ack;
      int   mark;
      int   ea;
      mark = wr_count;
      send_start();
      checkOutput("busy_start", 32'(BUSY), 32'd1);
      applyStimulus({4'hA, 3'(addr >> 8), 1'b0}, ack);
      checkOutput("wr_ctrl_ack", 32'(ack), 32'd1);
      applyStimulus(8'(addr), ack);
      checkOutput("wr_addr_ack", 32'(ack), 32'd1);
      for (int i = 0; i < n; i++) begin
         applyStimulus(data_buf[i], ack);
         checkOutput("wr_data_ack", 32'(ack), 32'd1);
      end
      send_stop();
      checkOutput("busy_stop", 32'(BUSY), 32'd0);
      checkOutput("wr_count", 32'(wr_count - mark), 32'(n));
      for (int i = 0; i < n; i++) begin
         ea = (addr & 'h7F0) | ((addr + i) & 'hF);
         model_mem[11'(ea)] = data_buf[i];
         checkOutput("wr_addr", 32'(wr_addr_log[8'(mark + i)]), 32'(ea));
         checkOutput("wr_data", 32'(wr_data_log[8'(mark + i)]), 32'(data_buf[i]));
      end
      model_ptr = (addr & 'h7F0) | ((addr + n) & 'hF);
   endtask

   // Random read: dummy write sets the pointer, repeated START, then read n bytes
   task automatic do_rand_read(input int addr, input int n);
      logic       ack;
      logic [7:0] d;
      send_start();
      applyStimulus({4'hA, 3'(addr >> 8), 1'b0}, ack);
      checkOutput("rr_ctrlw_ack", 32'(ack), 32'd1);
      applyStimulus(8'(addr), ack);
      checkOutput("rr_addr_ack", 32'(ack), 32'd1);
      send_start();
      applyStimulus({4'hA, 3'(addr >> 8), 1'b1}, ack);
      checkOutput("rr_ctrlr_ack", 32'(ack), 32'd1);
      for (int i = 0; i < n; i++) begin
         read_byte(i < n - 1, d);
         checkOutput("rr_data", 32'(d), 32'(model_mem[11'((addr + i) & 'h7FF)]));
      end
      checkOutput("rr_release", 32'(SDA_OE), 32'd0);
      send_stop();
      checkOutput("rr_busy_stop", 32'(BUSY), 32'd0);
      model_ptr = (addr + n) & 'h7FF;
   endtask

   // Current-address read continuing from the model's pointer
   task automatic do_cur_read(input int n);
      logic       ack;
      logic [7:0] d;
      send_start();
      applyStimulus({4'hA, 3'(model_ptr >> 8), 1'b1}, ack);
      checkOutput("cr_ctrl_ack", 32'(ack), 32'd1);
      for (int i = 0; i < n; i++) begin
         read_byte(i < n - 1, d);
         checkOutput("cr_data", 32'(d), 32'(model_mem[11'((model_ptr + i) & 'h7FF)]));
      end
      send_stop();
      model_ptr = (model_ptr + n) & 'h7FF;
   endtask

   initial begin
      int   mark;
      int   oe_mark;
      logic ack;
      logic s;
      RESET      = 1'b1;
      SCL        = 1'b1;
      sda_master = 1'b1;
      preload_en = 1'b0;
`ifdef EEPROM_WRITE_PROTECT_EN
      WP = 1'b0;
`endif
      for (int i = 0; i < 2048; i++) begin
         preload(11'(i), 8'($urandom));
      end

      // Reset state
      checkOutput("rst_sda_oe", 32'(SDA_OE), 32'd0);
      checkOutput("rst_mem_we", 32'(MEM_WE), 32'd0);
      checkOutput("rst_mem_addr", 32'(MEM_ADDR), 32'd0);
      checkOutput("rst_mem_wdata", 32'(MEM_WDATA), 32'd0);
      checkOutput("rst_busy", 32'(BUSY), 32'd0);
      RESET = 1'b0;
      repeat (4) @(negedge CLK);

      // Byte write 0xA4 0x3C 0x5A -> 0x23C
      $display("[TB] byte write");
      data_buf[0] = 8'h5A;
      do_write('h23C, 1);

      // Page wrap from 0x00E
      $display("[TB] page wrap");
      data_buf[0] = 8'h11;
      data_buf[1] = 8'h22;
      data_buf[2] = 8'h33;
      do_write('h00E, 3);

      // Random read across the top of memory
      $display("[TB] random read with pointer wrap");
      preload(11'h7FF, 8'hC3);
      preload(11'h000, 8'h3C);
      do_rand_read('h7FF, 2);

      // Wrong device type
      $display("[TB] wrong device");
      mark    = wr_count;
      oe_mark = oe_count;
      send_start();
      applyStimulus(8'h90, ack);
      checkOutput("wd_ctrl_nack", 32'(ack), 32'd0);
      applyStimulus(8'hA0, ack);
      checkOutput("wd_byte1_nack", 32'(ack), 32'd0);
      applyStimulus(8'h55, ack);
      checkOutput("wd_byte2_nack", 32'(ack), 32'd0);
      send_stop();
      checkOutput("wd_no_oe", 32'(oe_count - oe_mark), 32'd0);
      checkOutput("wd_no_we", 32'(wr_count - mark), 32'd0);
      checkOutput("wd_busy", 32'(BUSY), 32'd0);

      // Abort mid data byte
      $display("[TB] abort");
      mark = wr_count;
      send_start();
      applyStimulus(8'hA0, ack);
      checkOutput("ab_ctrl_ack", 32'(ack), 32'd1);
      applyStimulus(8'h10, ack);
      checkOutput("ab_addr_ack", 32'(ack), 32'd1);
      for (int i = 0; i < 4; i++) begin
         clock_bit(1'($urandom), s);
      end
      send_stop();
      checkOutput("ab_no_we", 32'(wr_count - mark), 32'd0);
      checkOutput("ab_busy", 32'(BUSY), 32'd0);
      checkOutput("ab_sda_oe", 32'(SDA_OE), 32'd0);
      data_buf[0] = 8'($urandom);
      do_write('h010, 1);

`ifdef EEPROM_WRITE_PROTECT_EN
      // Write protect: bytes ACKed but memory untouched
      $display("[TB] write protect");
      WP   = 1'b1;
      mark = wr_count;
      send_start();
      applyStimulus(8'hA0, ack);
      checkOutput("wp_ctrl_ack", 32'(ack), 32'd1);
      applyStimulus(8'h10, ack);
      checkOutput("wp_addr_ack", 32'(ack), 32'd1);
      applyStimulus(8'h77, ack);
      checkOutput("wp_data_ack", 32'(ack), 32'd1);
      send_stop();
      checkOutput("wp_no_we", 32'(wr_count - mark), 32'd0);
      WP = 1'b0;
      model_ptr = 'h011;
      do_cur_read(1);
`endif

      // Randomized writes and reads against the model
      $display("[TB] randomized traffic");
      for (int it = 0; it < 6; it++) begin
         int a;
         int n;
         a = int'($urandom_range(0, 2047));
         n = int'($urandom_range(1, 4));
         for (int i = 0; i < n; i++) begin
            data_buf[i] = 8'($urandom);
         end
         do_write(a, n);
         do_rand_read(int'($urandom_range(0, 2047)), int'($urandom_range(1, 3)));
         do_cur_read(2);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/eeprom_slave_rsp.md
Name: eeprom_slave_rsp

Overview:
- I2C-style serial EEPROM responder: the slave end of the 24C16-type protocol driven by the EEPROM write/read master.
- Decodes START/STOP, control byte, word address, and write/read data bytes; generates ACK and read data on SDA.
- Drives an external synchronous byte memory (2K x 8).
- Used as the synthesizable device model in system benches and on FPGA loopback builds.

Parameters:
- ADDR_W, 11, memory address width; control byte bits [3:1] carry ADDR[10:8].
- PAGE_BITS, 4, page size is 2**PAGE_BITS bytes; write auto-increment wraps inside the page.
- SYNC_STAGES, 2, synchronizer depth on SCL and SDA.
- DEV_TYPE, 4'b1010, required control byte bits [7:4].

Ports:
- CLK  in  1  system clock; must be at least 8x the SCL frequency.
- RESET  in  1  synchronous reset, active-high.
- SCL  in  1  serial clock from master.
- SDA_IN  in  1  sampled SDA line.
- SDA_OE  out  1  1 pulls SDA low; 0 releases the line. The pad is open-drain, external to this block.
- MEM_ADDR  out  ADDR_W  memory address.
- MEM_WDATA  out  8  write data.
- MEM_WE  out  1  one-CLK write strobe.
- MEM_RDATA  in  8  read data, valid 1 CLK after MEM_ADDR.
- BUSY  out  1  high from a decoded START until STOP or abort.

Behaviour:
- Reset (synchronous, RESET=1 at a CLK posedge): SDA_OE=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, BUSY=0, state=IDLE, bit counter=0.
- Line decode, all on synchronized signals:
  - SCL rise/fall = edge of the synced SCL.
  - START = SDA falls while SCL=1.
  - STOP = SDA rises while SCL=1.
  - Data bits are sampled on SCL rise, MSB first. SDA_OE changes only in the CLK after an SCL fall.
- START in any state, including a repeated START mid-byte: bit counter=0, SDA_OE=0, BUSY=1, go to CTRL. The address pointer is kept.
- STOP in any state: SDA_OE=0, BUSY=0, go to IDLE. A partial data byte is discarded; no write occurs.
- States:
  - IDLE: ignore all bits.
  - CTRL: shift 8 bits.
    - If [7:4]==DEV_TYPE: load ptr[10:8]=byte[3:1], latch R/W=byte[0], go to CTRL_ACK.
    - Otherwise go to WAIT (no ACK; line stays released).
  - CTRL_ACK: assert SDA_OE after the 8th SCL fall; release after the 9th SCL fall.
    - If R/W=0, go to ADDR.
    - If R/W=1, go to RDATA; MEM_ADDR=ptr is presented at ACK start so the byte is loaded before bit 7.
  - ADDR: shift 8 bits into ptr[7:0], then ADDR_ACK, then WDATA.
  - WDATA: shift 8 bits.
    - On the 8th SCL rise: MEM_WDATA=byte, MEM_ADDR=ptr, MEM_WE=1 for exactly 1 CLK.
    - Then WDATA_ACK. ptr low PAGE_BITS increment modulo page; upper bits unchanged (0x00F -> 0x000 when PAGE_BITS=4).
  - RDATA: drive shift-register MSB.
    - SDA_OE = ~bit. First bit is driven after the CTRL_ACK release.
    - After 8 bits, release SDA and go to RDATA_ACK. ptr increments across the full ADDR_W range and wraps 0x7FF -> 0x000.
  - RDATA_ACK: sample SDA on the 9th SCL rise.
    - 0 (ACK): present MEM_ADDR=ptr and go to RDATA.
    - 1 (NACK): go to WAIT.
  - WAIT: line released; leave only on START or STOP.
- Random read = write CTRL + ADDR, repeated START, read CTRL. Reads start at the loaded ptr.
- START and STOP in the same CLK cannot occur (they require opposite SDA edges). Simultaneous SCL edge + START: START wins.
- SDA_OE is never asserted while SCL=1 except during an ACK or data bit that was already set up on the preceding SCL fall.

Optional Feature:
- Macro: EEPROM_WRITE_PROTECT_EN.
- Defined: adds input WP (1 bit).
  - While WP=1, WDATA bytes are still ACKed and ptr still advances, but MEM_WE stays 0.
  - WP is sampled at the 8th SCL rise of each data byte.
- Undefined: no WP port; writes are always performed.

Decomposition:
- Package eeprom_pkg:
  - state enum (IDLE, CTRL, CTRL_ACK, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT);
  - DEV_TYPE_DEFAULT = 4'b1010;
  - ADDR_W default.
- Sub-module i2c_line_detect: synchronizers plus scl_rise, scl_fall, start, stop, and sda_s one-CLK pulses/levels.

Test Plan:
- Byte write: START, 0xA4, 0x3C, 0x5A, STOP.
  - Required: ACK on all three bytes; MEM_WE pulses once with MEM_ADDR=0x23C, MEM_WDATA=0x5A.
  - Required: BUSY falls on STOP.
- Page wrap: write to 0x00E with data 0x11, 0x22, 0x33.
  - Required: writes at 0x00E, 0x00F, 0x000.
- Random read: preload 0x7FF=0xC3, 0x000=0x3C. Send START, 0xAE, 0xFF, repeated START, 0xAF, then read two bytes with master ACK then NACK, then STOP.
  - Required: SDA shows 0xC3 then 0x3C (pointer wraps); line released after NACK.
- Wrong device: START, 0x90.
  - Required: no ACK (SDA_OE stays 0); subsequent bytes ignored until STOP; no MEM_WE.
- Abort: STOP after 4 data bits of WDATA.
  - Required: no MEM_WE; state IDLE; next transaction works normally.
- With EEPROM_WRITE_PROTECT_EN and WP=1: byte write 0xA0, 0x10, 0x77.
  - Required: all bytes ACKed; MEM_WE never asserted.
